// File: rtl/dmem_bridge_pkg.sv
// Shared types for the data-memory bridge: access sizes, FSM states and
// the alignment rule used by both the bridge and its testbench.
package dmem_bridge_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2
   } mem_size_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } bridge_state_t;

   // Natural alignment: halves on even addresses, words on multiples of four.
   function automatic logic is_aligned(input mem_size_t size, input logic [1:0] addr_lo);
      logic ok;
      case (size)
         MEM_BYTE: ok = 1'b1;
         MEM_HALF: ok = ~addr_lo[0];
         default:  ok = (addr_lo == 2'b00);
      endcase
      is_aligned = ok;
   endfunction

endpackage

// File: rtl/dmem_bridge_align.sv
// Byte-lane steering for the data-memory bridge: store replication and
// strobes on the way out, load shifting and extension on the way back.
module dmem_align
   import dmem_bridge_pkg::*;
(
   input  mem_size_t   st_size,
   input  logic [1:0]  st_addr_lo,
   input  logic [31:0] st_wdata,
   output logic [31:0] st_bus_wdata,
   output logic [3:0]  st_wstrb,
   input  mem_size_t   ld_size,
   input  logic [1:0]  ld_addr_lo,
   input  logic        ld_unsigned,
   input  logic [31:0] ld_bus_rdata,
   output logic [31:0] ld_data
);

   logic [31:0] ld_shifted;

   // Replicate narrow store data into every lane and enable only the addressed bytes.
   always_comb begin
      st_bus_wdata = st_wdata;
      st_wstrb     = 4'b1111;
      case (st_size)
         MEM_BYTE: begin
            st_bus_wdata = {4{st_wdata[7:0]}};
            st_wstrb     = 4'b0001 << st_addr_lo;
         end
         MEM_HALF: begin
            st_bus_wdata = {2{st_wdata[15:0]}};
            st_wstrb     = st_addr_lo[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
         end
      endcase
   end

   // Bring the addressed lane down to bit 0, then sign- or zero-extend to 32 bits.
   always_comb begin
      ld_shifted = ld_bus_rdata >> {ld_addr_lo, 3'b000};
      ld_data    = ld_shifted;
      case (ld_size)
         MEM_BYTE: ld_data = {{24{~ld_unsigned & ld_shifted[7]}}, ld_shifted[7:0]};
         MEM_HALF: ld_data = {{16{~ld_unsigned & ld_shifted[15]}}, ld_shifted[15:0]};
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/dmem_bridge.sv
// MEM-stage data-memory bridge: turns a pipeline load/store into a single
// valid/ready bus transaction, stalling the pipeline until it completes.
module dmem_bridge
   import dmem_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_read,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   input  mem_size_t             req_size,
   input  logic                  req_unsigned,
   input  logic                  pipe_enable,
   output logic                  dmem_wait,
   output logic [31:0]           rdata,
   output logic                  misaligned,
   output logic                  bus_valid,
   output logic                  bus_write,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [31:0]           bus_wdata,
   output logic [3:0]            bus_wstrb,
   input  logic                  bus_ready,
   input  logic                  bus_rvalid,
   input  logic [31:0]           bus_rdata
);

   bridge_state_t         state_q, state_d;
   logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
   logic                  bus_write_q, bus_write_d;
   logic [31:0]           bus_wdata_q, bus_wdata_d;
   logic [3:0]            bus_wstrb_q, bus_wstrb_d;
   logic [1:0]            addr_lo_q, addr_lo_d;
   mem_size_t             size_q, size_d;
   logic                  unsigned_q, unsigned_d;
   logic [31:0]           rdata_q, rdata_d;

   logic                  req_any;
   logic                  req_aligned;
   logic [31:0]           st_bus_wdata;
   logic [3:0]            st_wstrb;
   logic [31:0]           ld_data;

   assign req_any     = req_read | req_write;
   assign req_aligned = is_aligned(req_size, req_addr[1:0]);
   assign misaligned  = req_any & ~req_aligned;
   assign rdata       = misaligned ? 32'h0 : rdata_q;
   assign bus_addr    = bus_addr_q;
   assign bus_write   = bus_write_q;
   assign bus_wdata   = bus_wdata_q;
   assign bus_wstrb   = bus_wstrb_q;

   // Store lanes come from the live request; load extension uses the attributes latched at launch.
   dmem_align u_align (
      .st_size      (req_size),
      .st_addr_lo   (req_addr[1:0]),
      .st_wdata     (req_wdata),
      .st_bus_wdata (st_bus_wdata),
      .st_wstrb     (st_wstrb),
      .ld_size      (size_q),
      .ld_addr_lo   (addr_lo_q),
      .ld_unsigned  (unsigned_q),
      .ld_bus_rdata (bus_rdata),
      .ld_data      (ld_data)
   );

   // Next-state and outputs; dmem_wait looks only at state and request, never at pipe_enable.
   always_comb begin
      state_d     = state_q;
      bus_addr_d  = bus_addr_q;
      bus_write_d = bus_write_q;
      bus_wdata_d = bus_wdata_q;
      bus_wstrb_d = bus_wstrb_q;
      addr_lo_d   = addr_lo_q;
      size_d      = size_q;
      unsigned_d  = unsigned_q;
      rdata_d     = rdata_q;
      dmem_wait   = 1'b0;
      bus_valid   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            dmem_wait = req_any & req_aligned;
            if (req_any && req_aligned) begin
               state_d     = ST_REQ;
               bus_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
               bus_write_d = req_write;
               bus_wdata_d = st_bus_wdata;
               bus_wstrb_d = req_write ? st_wstrb : 4'b0000;
               addr_lo_d   = req_addr[1:0];
               size_d      = req_size;
               unsigned_d  = req_unsigned;
            end
         end
         ST_REQ: begin
            dmem_wait = 1'b1;
            bus_valid = 1'b1;
            if (bus_ready) begin
               state_d = bus_write_q ? ST_DONE : ST_RESP;
            end
         end
         ST_RESP: begin
            dmem_wait = 1'b1;
            if (bus_rvalid) begin
               rdata_d = ld_data;
               state_d = ST_DONE;
            end
         end
         default: begin
            if (pipe_enable) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   // State and bus-request registers; reset drops any transaction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         bus_addr_q  <= '0;
         bus_write_q <= 1'b0;
         bus_wdata_q <= 32'h0;
         bus_wstrb_q <= 4'b0000;
         addr_lo_q   <= 2'b00;
         size_q      <= MEM_BYTE;
         unsigned_q  <= 1'b0;
         rdata_q     <= 32'h0;
      end else begin
         state_q     <= state_d;
         bus_addr_q  <= bus_addr_d;
         bus_write_q <= bus_write_d;
         bus_wdata_q <= bus_wdata_d;
         bus_wstrb_q <= bus_wstrb_d;
         addr_lo_q   <= addr_lo_d;
         size_q      <= size_d;
         unsigned_q  <= unsigned_d;
         rdata_q     <= rdata_d;
      end
   end

endmodule

// File: tb/tb_dmem_bridge.sv
// Randomized testbench for dmem_bridge against a byte-level reference model.
module tb_dmem_bridge;
   import dmem_bridge_pkg::*;

   logic        clk;
   logic        reset;
   logic        req_read;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   mem_size_t   req_size;
   logic        req_unsigned;
   logic        pipe_enable;
   logic        dmem_wait;
   logic [31:0] rdata;
   logic        misaligned;
   logic        bus_valid;
   logic        bus_write;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_ready;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;

   int errors;
   int checks;

   // Model state: last value a completed load left in rdata
   logic [31:0] last_rdata;

   // Observations gathered by run_access
   int          obs_stalls;
   int          obs_pre_valid;
   logic [31:0] obs_addr;
   logic        obs_write;
   logic [31:0] obs_wdata;
   logic [3:0]  obs_wstrb;
   logic [31:0] obs_rdata;
   logic        obs_stable;
   logic        obs_hold_ok;
   logic        obs_timeout;
   logic        obs_misal;

   dmem_bridge #(.ADDR_WIDTH(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_read     (req_read),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .pipe_enable  (pipe_enable),
      .dmem_wait    (dmem_wait),
      .rdata        (rdata),
      .misaligned   (misaligned),
      .bus_valid    (bus_valid),
      .bus_write    (bus_write),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .bus_wstrb    (bus_wstrb),
      .bus_ready    (bus_ready),
      .bus_rvalid   (bus_rvalid),
      .bus_rdata    (bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference: value seen by the core for a load of the given size at byte offset lo
   function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] lo,
                                             input mem_size_t size, input logic uns);
      int unsigned v;
      case (size)
         MEM_BYTE: begin
            v = (word >> (8 * lo)) % 256;
            if (!uns && v >= 128) v = v + 32'hFFFFFF00;
         end
         MEM_HALF: begin
            v = (word >> (8 * lo)) % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF0000;
         end
         default: v = word;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] w, input mem_size_t size);
      case (size)
         MEM_BYTE: return (w % 256) * 32'h01010101;
         MEM_HALF: return (w % 65536) * 32'h00010001;
         default:  return w;
      endcase
   endfunction

   function automatic logic [3:0] model_wstrb(input logic [1:0] lo, input mem_size_t size);
      case (size)
         MEM_BYTE: return 4'(1 << lo);
         MEM_HALF: return 4'(3 << lo);
         default:  return 4'hF;
      endcase
   endfunction

   function automatic int model_stalls(input logic is_write, input int ready_delay, input int rvalid_delay);
      return 1 + ready_delay + 1 + (is_write ? 0 : rvalid_delay);
   endfunction

   // Drive one aligned access through a responsive bus model and record what was observed.
   task automatic run_access(input logic is_write, input logic [31:0] addr, input mem_size_t size,
                             input logic uns, input logic [31:0] wdata, input int ready_delay,
                             input int rvalid_delay, input logic [31:0] rd_bus, input int hold);
      int   cyc;
      int   valid_cycles;
      int   since_acc;
      logic accepted;
      cyc = 0; valid_cycles = 0; since_acc = 0; accepted = 1'b0;
      obs_stalls = 0; obs_pre_valid = 0; obs_stable = 1'b1; obs_hold_ok = 1'b1; obs_timeout = 1'b0;
      obs_addr = 32'h0; obs_write = 1'b0; obs_wdata = 32'h0; obs_wstrb = 4'h0; obs_misal = 1'b0;
      @(negedge clk);
      req_read = ~is_write; req_write = is_write; req_addr = addr; req_size = size;
      req_unsigned = uns; req_wdata = wdata;
      forever begin
         #1;
         if (cyc == 0) obs_misal = misaligned;
         if (cyc > 0 && dmem_wait === 1'b0) break;
         if (cyc >= 60) begin
            obs_timeout = 1'b1;
            break;
         end
         if (dmem_wait === 1'b1) obs_stalls++;
         pipe_enable = 1'($urandom_range(0, 1));
         if (accepted && !is_write) begin
            since_acc++;
            bus_rvalid = (since_acc == rvalid_delay);
            bus_rdata  = bus_rvalid ? rd_bus : $urandom;
         end else begin
            bus_rvalid = 1'($urandom_range(0, 1));
            bus_rdata  = $urandom;
         end
         if (bus_valid === 1'b1) begin
            if (valid_cycles == 0) begin
               obs_addr = bus_addr; obs_write = bus_write; obs_wdata = bus_wdata; obs_wstrb = bus_wstrb;
            end else if (bus_addr !== obs_addr || bus_write !== obs_write ||
                         bus_wdata !== obs_wdata || bus_wstrb !== obs_wstrb) begin
               obs_stable = 1'b0;
            end
            bus_ready = (valid_cycles >= ready_delay);
            valid_cycles++;
            if (bus_ready) accepted = 1'b1;
         end else begin
            if (valid_cycles == 0) obs_pre_valid++;
            bus_ready = 1'($urandom_range(0, 1));
         end
         cyc++;
         @(negedge clk);
      end
      obs_rdata = rdata;
      for (int h = 0; h < hold; h++) begin
         pipe_enable = 1'b0;
         bus_rvalid  = 1'b1;
         bus_rdata   = $urandom;
         bus_ready   = 1'($urandom_range(0, 1));
         @(negedge clk);
         #1;
         if (rdata !== obs_rdata || dmem_wait !== 1'b0 || bus_valid !== 1'b0) obs_hold_ok = 1'b0;
      end
      pipe_enable = 1'b1;
      bus_rvalid  = 1'b0;
      bus_ready   = 1'b0;
      @(posedge clk);
   endtask

   task automatic go_idle();
      @(negedge clk);
      req_read = 1'b0; req_write = 1'b0; pipe_enable = 1'b1;
      bus_ready = 1'b0; bus_rvalid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_read = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      req_size = MEM_BYTE; req_unsigned = 1'b0; pipe_enable = 1'b1;
      bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
      last_rdata = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (bus_valid !== 1'b0 || bus_write !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_ctrl: valid=%b write=%b, required 0 0", bus_valid, bus_write);
      end
      checks++;
      if (bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_wstrb !== 4'h0) begin
         errors++; $display("[TB] FAIL reset_bus: addr=%h wdata=%h wstrb=%b, required zeros", bus_addr, bus_wdata, bus_wstrb);
      end
      checks++;
      if (rdata !== 32'h0 || dmem_wait !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_out: rdata=%h wait=%b, required 0 0", rdata, dmem_wait);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_store_word();
      run_access(1'b1, 32'h100, MEM_WORD, 1'b0, 32'hDEADBEEF, 0, 1, 32'h0, 0);
      checks++;
      if (obs_timeout !== 1'b0) begin errors++; $display("[TB] FAIL sw_timeout: got timeout, required completion"); end
      checks++;
      if (obs_addr !== 32'h100 || obs_write !== 1'b1) begin
         errors++; $display("[TB] FAIL sw_addr: addr=%h write=%b, required 00000100 1", obs_addr, obs_write);
      end
      checks++;
      if (obs_wdata !== 32'hDEADBEEF || obs_wstrb !== 4'b1111) begin
         errors++; $display("[TB] FAIL sw_data: wdata=%h wstrb=%b, required deadbeef 1111", obs_wdata, obs_wstrb);
      end
      checks++;
      if (obs_stalls != 2) begin errors++; $display("[TB] FAIL sw_stalls: got %0d, required 2", obs_stalls); end
   endtask

   task automatic test_load_byte();
      logic [31:0] exp;
      run_access(1'b0, 32'h103, MEM_BYTE, 1'b0, 32'h0, 0, 1, 32'h80FF_0000, 0);
      exp = model_load(32'h80FF_0000, 2'd3, MEM_BYTE, 1'b0);
      last_rdata = exp;
      checks++;
      if (obs_rdata !== 32'hFFFFFF80 || exp !== 32'hFFFFFF80) begin
         errors++; $display("[TB] FAIL lb_rdata: got %h, required ffffff80", obs_rdata);
      end
      checks++;
      if (obs_stalls != 3 || obs_addr !== 32'h100 || obs_write !== 1'b0) begin
         errors++; $display("[TB] FAIL lb_bus: stalls=%0d addr=%h write=%b, required 3 00000100 0", obs_stalls, obs_addr, obs_write);
      end
      checks++;
      if (obs_pre_valid != 1) begin errors++; $display("[TB] FAIL lb_gap: idle cycles=%0d, required 1", obs_pre_valid); end
      run_access(1'b0, 32'h103, MEM_BYTE, 1'b1, 32'h0, 0, 1, 32'h80FF_0000, 0);
      last_rdata = model_load(32'h80FF_0000, 2'd3, MEM_BYTE, 1'b1);
      checks++;
      if (obs_rdata !== 32'h00000080) begin errors++; $display("[TB] FAIL lbu_rdata: got %h, required 00000080", obs_rdata); end
   endtask

   task automatic test_store_half();
      run_access(1'b1, 32'h102, MEM_HALF, 1'b0, 32'hABCD1234, 0, 1, 32'h0, 0);
      checks++;
      if (obs_wdata !== 32'h12341234 || obs_wstrb !== 4'b1100) begin
         errors++; $display("[TB] FAIL sh_data: wdata=%h wstrb=%b, required 12341234 1100", obs_wdata, obs_wstrb);
      end
      checks++;
      if (obs_rdata !== last_rdata || obs_stalls != 2) begin
         errors++; $display("[TB] FAIL sh_done: rdata=%h stalls=%0d, required %h 2", obs_rdata, obs_stalls, last_rdata);
      end
   endtask

   task automatic test_misaligned();
      logic bad;
      bad = 1'b0;
      @(negedge clk);
      req_read = 1'b1; req_write = 1'b0; req_addr = 32'h101; req_size = MEM_WORD; req_unsigned = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pipe_enable = 1'($urandom_range(0, 1));
         bus_ready   = 1'($urandom_range(0, 1));
         #1;
         if (misaligned !== 1'b1 || dmem_wait !== 1'b0 || bus_valid !== 1'b0 || rdata !== 32'h0) bad = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (bad) begin
         errors++; $display("[TB] FAIL lw_misaligned: mis=%b wait=%b valid=%b rdata=%h, required 1 0 0 0", misaligned, dmem_wait, bus_valid, rdata);
      end
      req_addr = 32'h103; req_size = MEM_HALF; req_write = 1'b1; req_read = 1'b0;
      #1;
      checks++;
      if (misaligned !== 1'b1 || dmem_wait !== 1'b0) begin
         errors++; $display("[TB] FAIL sh_misaligned: mis=%b wait=%b, required 1 0", misaligned, dmem_wait);
      end
      go_idle();
      #1;
      checks++;
      if (rdata !== last_rdata) begin errors++; $display("[TB] FAIL mis_restore: rdata=%h, required %h", rdata, last_rdata); end
   endtask

   task automatic test_stall_hold();
      logic [31:0] rd;
      rd = $urandom;
      run_access(1'b0, 32'h200, MEM_WORD, 1'b0, 32'h0, 3, 2, rd, 2);
      last_rdata = model_load(rd, 2'd0, MEM_WORD, 1'b0);
      checks++;
      if (obs_stable !== 1'b1) begin errors++; $display("[TB] FAIL hold_bus_stable: got unstable, required stable"); end
      checks++;
      if (obs_stalls != model_stalls(1'b0, 3, 2)) begin
         errors++; $display("[TB] FAIL hold_stalls: got %0d, required %0d", obs_stalls, model_stalls(1'b0, 3, 2));
      end
      checks++;
      if (obs_rdata !== last_rdata) begin errors++; $display("[TB] FAIL hold_rdata: got %h, required %h", obs_rdata, last_rdata); end
      checks++;
      if (obs_hold_ok !== 1'b1) begin errors++; $display("[TB] FAIL hold_done: left DONE or rdata moved without pipe_enable"); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         run_access(1'(i % 2), 32'h400 + 32'(4 * i), MEM_WORD, 1'b0, $urandom, 0, 1, 32'h0BAD_F00D + 32'(i), 0);
         if (i % 2 == 0) last_rdata = 32'h0BAD_F00D + 32'(i);
         checks++;
         if (obs_pre_valid != 1 || obs_stalls != model_stalls(1'(i % 2), 0, 1) || obs_rdata !== last_rdata) begin
            errors++; $display("[TB] FAIL b2b_%0d: idle=%0d stalls=%0d rdata=%h, required 1 %0d %h", i, obs_pre_valid, obs_stalls, obs_rdata, model_stalls(1'(i % 2), 0, 1), last_rdata);
         end
      end
   endtask

   task automatic test_reset_mid_resp();
      logic bad;
      bad = 1'b0;
      @(negedge clk);
      req_read = 1'b1; req_write = 1'b0; req_addr = 32'h300; req_size = MEM_WORD; req_unsigned = 1'b0;
      pipe_enable = 1'b0; bus_ready = 1'b1; bus_rvalid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (dmem_wait !== 1'b1 || bus_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL resp_entry: wait=%b valid=%b, required 1 0", dmem_wait, bus_valid);
      end
      req_read = 1'b0;
      reset = 1'b1;
      #1;
      checks++;
      if (bus_valid !== 1'b0 || rdata !== 32'h0 || bus_addr !== 32'h0 || bus_wstrb !== 4'h0 || dmem_wait !== 1'b0) begin
         errors++; $display("[TB] FAIL mid_reset: valid=%b rdata=%h addr=%h wait=%b, required 0 0 0 0", bus_valid, rdata, bus_addr, dmem_wait);
      end
      bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_BABE;
      @(negedge clk);
      reset = 1'b0;
      last_rdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         if (rdata !== 32'h0 || dmem_wait !== 1'b0 || bus_valid !== 1'b0) bad = 1'b1;
      end
      bus_rvalid = 1'b0;
      checks++;
      if (bad) begin errors++; $display("[TB] FAIL late_rvalid: rdata=%h wait=%b, required 0 0", rdata, dmem_wait); end
      run_access(1'b1, 32'h500, MEM_BYTE, 1'b0, 32'h5A, 0, 1, 32'h0, 0);
      checks++;
      if (obs_stalls != 2 || obs_pre_valid != 1 || obs_rdata !== 32'h0 || obs_wstrb !== 4'b0001) begin
         errors++; $display("[TB] FAIL post_reset_sb: stalls=%0d idle=%0d rdata=%h wstrb=%b, required 2 1 0 0001", obs_stalls, obs_pre_valid, obs_rdata, obs_wstrb);
      end
   endtask

   task automatic test_random();
      logic        is_write;
      mem_size_t   size;
      logic [1:0]  lo;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd;
      logic [31:0] exp;
      int          rdly;
      int          vdly;
      int          hold;
      for (int n = 0; n < 24; n++) begin
         is_write = 1'($urandom_range(0, 1));
         size     = mem_size_t'($urandom_range(0, 2));
         lo       = (size == MEM_BYTE) ? 2'($urandom_range(0, 3)) : (size == MEM_HALF) ? 2'(2 * $urandom_range(0, 1)) : 2'd0;
         addr     = 32'h1000 + 32'(4 * $urandom_range(0, 255)) + 32'(lo);
         uns      = 1'($urandom_range(0, 1));
         wdata    = $urandom;
         rd       = $urandom;
         rdly     = $urandom_range(0, 3);
         vdly     = $urandom_range(1, 3);
         hold     = $urandom_range(0, 2);
         run_access(is_write, addr, size, uns, wdata, rdly, vdly, rd, hold);
         if (!is_write) last_rdata = model_load(rd, lo, size, uns);
         exp = last_rdata;
         checks++;
         if (obs_timeout !== 1'b0 || obs_misal !== 1'b0 || obs_pre_valid != 1 ||
             obs_stalls != model_stalls(is_write, rdly, vdly)) begin
            errors++; $display("[TB] FAIL rnd_%0d_timing: to=%b mis=%b idle=%0d stalls=%0d, required 0 0 1 %0d", n, obs_timeout, obs_misal, obs_pre_valid, obs_stalls, model_stalls(is_write, rdly, vdly));
         end
         checks++;
         if (obs_addr !== {addr[31:2], 2'b00} || obs_write !== is_write || obs_stable !== 1'b1) begin
            errors++; $display("[TB] FAIL rnd_%0d_req: addr=%h write=%b stable=%b, required %h %b 1", n, obs_addr, obs_write, obs_stable, {addr[31:2], 2'b00}, is_write);
         end
         if (is_write) begin
            checks++;
            if (obs_wdata !== model_wdata(wdata, size) || obs_wstrb !== model_wstrb(lo, size)) begin
               errors++; $display("[TB] FAIL rnd_%0d_store: wdata=%h wstrb=%b, required %h %b", n, obs_wdata, obs_wstrb, model_wdata(wdata, size), model_wstrb(lo, size));
            end
         end
         checks++;
         if (obs_rdata !== exp || obs_hold_ok !== 1'b1) begin
            errors++; $display("[TB] FAIL rnd_%0d_rdata: got %h hold_ok=%b, required %h 1", n, obs_rdata, obs_hold_ok, exp);
         end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_store_word();
      test_load_byte();
      test_store_half();
      test_misaligned();
      test_stall_hold();
      test_back_to_back();
      test_reset_mid_resp();
      test_random();
      go_idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the byte-address width of req_addr and bus_addr.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-004 req_read / req_write  in  1 each  SHALL flag a MEM-stage load or store; both high is illegal.
REQ-005 req_addr  in  ADDR_WIDTH  SHALL be the byte address; req_wdata  in  32  SHALL be the store data, LSB-aligned.
REQ-006 req_size  in  mem_size_t (BYTE/HALF/WORD)  SHALL be the access size; req_unsigned  in  1  SHALL select zero-extension.
REQ-007 pipe_enable  in  1  SHALL indicate the pipeline advances this cycle.
REQ-008 dmem_wait  out  1  SHALL stall the pipeline; rdata  out  32  SHALL be the extended load result; misaligned  out  1  SHALL flag an unaligned access.
REQ-009 bus_valid, bus_write  out  1; bus_addr  out  ADDR_WIDTH; bus_wdata  out  32; bus_wstrb  out  4  SHALL form the bus request.
REQ-010 bus_ready, bus_rvalid  in  1; bus_rdata  in  32  SHALL be the bus acceptance and read response.

Function
REQ-011 The FSM SHALL have states IDLE, REQ, RESP, DONE.
REQ-012 IDLE: dmem_wait = (req_read|req_write) & aligned, combinational; an aligned request SHALL move to REQ next cycle.
REQ-013 REQ: bus_valid=1, with bus_addr word-aligned (low 2 bits 0) and bus_write/bus_wdata/bus_wstrb registered at IDLE exit and held stable until bus_ready.
REQ-014 REQ with bus_ready=1: store SHALL go to DONE; load SHALL go to RESP; bus_valid SHALL drop the following cycle.
REQ-015 RESP: on bus_rvalid=1, bus_rdata SHALL be shifted by addr[1:0], size-masked, sign/zero-extended, and captured into rdata; then DONE.
REQ-016 dmem_wait SHALL be 1 in REQ and RESP, and 0 in DONE.
REQ-017 DONE: rdata SHALL hold; on pipe_enable=1 SHALL return to IDLE, else remain (imem stall).
REQ-018 Stores: BYTE SHALL replicate wdata[7:0] into all lanes with strobe 1<<addr[1:0]; HALF SHALL replicate wdata[15:0] with strobe 0011 or 1100; WORD strobe SHALL be 1111.
REQ-019 Misaligned (HALF with addr[0]=1, or WORD with addr[1:0]!=0) SHALL assert misaligned combinationally, issue no bus transaction, keep dmem_wait=0, and force rdata=0.
REQ-020 dmem_wait SHALL NOT depend combinationally on pipe_enable (no loop through the hazard unit).
REQ-021 bus_rvalid outside RESP and bus_ready outside REQ SHALL be ignored.
REQ-022 Back-to-back accesses SHALL incur exactly one IDLE cycle between DONE and the next REQ.
REQ-023 Minimum latency: store with bus_ready already high = 2 stall cycles; load with bus_ready high and bus_rvalid on the next cycle = 3 stall cycles.

Reset
REQ-024 reset SHALL immediately force state IDLE, bus_valid=0, bus_write=0, bus_wstrb=0, bus_addr=0, bus_wdata=0, and rdata=0, including mid-transaction.
REQ-025 After reset release, any in-flight bus response SHALL be ignored per REQ-021.

Structure
REQ-026 mem_size_t and the FSM state enum SHALL live in the shared types package.
REQ-027 Lane shifting, strobe generation and load extension SHALL be a combinational sub-module dmem_align.

Verification
REQ-028 SW to 0x100, wdata 0xDEADBEEF, bus_ready=1 -> bus_addr 0x100, wstrb 1111, dmem_wait high 2 cycles.
REQ-029 LB signed at 0x103, bus_rdata 0x80FF_0000 -> rdata 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-030 SH to 0x102, wdata 0x1234 -> bus_wdata 0x12341234, wstrb 1100.
REQ-031 LW at 0x101 -> misaligned=1, bus_valid never rises, dmem_wait=0.
REQ-032 LW with bus_ready delayed 3 cycles, then pipe_enable held 0 for 2 cycles in DONE -> bus_valid held stable; rdata stable; IDLE entered only after pipe_enable=1.
REQ-033 reset asserted during RESP -> bus_valid=0 and state IDLE at once; a late bus_rvalid leaves rdata=0.
